// File: rtl/mem_port_arbiter_if.sv
// Memory-side request/ready port shared by instruction fetch and the MEM stage.
// The arbiter drives the request side (master); the memory answers (slave).
interface mem_port_arbiter_if;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ready
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serializes instruction fetch and MEM-stage data accesses onto one variable-latency
// memory port, data first, with pipeline stalls, fetch kill on redirect and a wait timeout.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        i_if_req,
   input  logic [63:0] i_if_addr,
   input  logic        i_if_flush,
   output logic [31:0] o_if_rdata,
   output logic        o_if_valid,
   output logic        o_stall_if,

   input  logic        i_dm_read,
   input  logic        i_dm_write,
   input  logic [63:0] i_dm_addr,
   input  logic [63:0] i_dm_wdata,
   output logic [63:0] o_dm_rdata,
   output logic        o_dm_done,
   output logic        o_stall_mem,

   output logic        o_timeout_err,

   mem_port_arbiter_if.master mem
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FETCH = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t      r_state;
   logic        r_memReq;
   logic        r_memWe;
   logic [63:0] r_memAddr;
   logic [63:0] r_memWdata;
   logic [63:0] r_dmRdata;
   logic [31:0] r_ifRdata;
   logic        r_dmDone;
   logic        r_ifValid;
   logic        r_timeoutErr;
   logic        r_kill;
   logic [7:0]  r_waitCnt;

   logic w_dataReq;
   logic w_arb;
   logic w_complete;
   logic w_waiting;
   logic w_grantData;
   logic w_fetchOk;
   logic w_grantFetch;

   // Arbitration happens in IDLE and again on the edge that completes an access, so the
   // requester that just finished is excluded until its done/valid pulse has been seen.
   // A killed fetch may be re-granted at once because the request now carries the new address.
   assign w_dataReq    = i_dm_read | i_dm_write;
   assign w_complete   = (r_state != IDLE) & mem.mem_ready;
   assign w_arb        = (r_state == IDLE) | w_complete;
   assign w_waiting    = r_memReq & ~mem.mem_ready;
   assign w_grantData  = w_arb & w_dataReq & ~r_dmDone & (r_state != DATA);
   assign w_fetchOk    = i_if_req & ~r_ifValid & ~i_if_flush & ((r_state != FETCH) | r_kill);
   assign w_grantFetch = w_arb & w_fetchOk & ~w_grantData;

   // Single FSM register block: completion capture, kill tracking, grant and wait counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_memReq     <= 1'b0;
         r_memWe      <= 1'b0;
         r_memAddr    <= '0;
         r_memWdata   <= '0;
         r_dmRdata    <= '0;
         r_ifRdata    <= '0;
         r_dmDone     <= 1'b0;
         r_ifValid    <= 1'b0;
         r_timeoutErr <= 1'b0;
         r_kill       <= 1'b0;
         r_waitCnt    <= '0;
      end else begin
         r_dmDone  <= 1'b0;
         r_ifValid <= 1'b0;

         if (w_complete) begin
            if (r_state == DATA) begin
               if (!r_memWe) begin
                  r_dmRdata <= mem.mem_rdata;
               end
               r_dmDone <= 1'b1;
            end else begin
               if (!(r_kill | i_if_flush)) begin
                  r_ifRdata <= r_memAddr[2] ? mem.mem_rdata[63:32] : mem.mem_rdata[31:0];
                  r_ifValid <= 1'b1;
               end
               r_kill <= 1'b0;
            end
         end else if ((r_state == FETCH) && i_if_flush) begin
            r_kill <= 1'b1;
         end

         if (w_grantData) begin
            r_state    <= DATA;
            r_memReq   <= 1'b1;
            r_memWe    <= i_dm_write;
            r_memAddr  <= i_dm_addr;
            r_memWdata <= i_dm_wdata;
            r_waitCnt  <= '0;
         end else if (w_grantFetch) begin
            r_state   <= FETCH;
            r_memReq  <= 1'b1;
            r_memWe   <= 1'b0;
            r_memAddr <= i_if_addr;
            r_waitCnt <= '0;
         end else if (w_complete) begin
            r_state  <= IDLE;
            r_memReq <= 1'b0;
            r_memWe  <= 1'b0;
         end else if (w_waiting) begin
            if (r_waitCnt != 8'hFF) begin
               r_waitCnt <= r_waitCnt + 8'd1;
            end
            if (r_waitCnt == (TIMEOUT_LIMIT - 8'd1)) begin
               r_timeoutErr <= 1'b1;
            end
         end
      end
   end

   assign mem.mem_req   = r_memReq;
   assign mem.mem_we    = r_memWe;
   assign mem.mem_addr  = r_memAddr;
   assign mem.mem_wdata = r_memWdata;

   assign o_if_rdata    = r_ifRdata;
   assign o_if_valid    = r_ifValid;
   assign o_dm_rdata    = r_dmRdata;
   assign o_dm_done     = r_dmDone;
   assign o_timeout_err = r_timeoutErr;

   assign o_stall_if  = i_if_req & ~r_ifValid;
   assign o_stall_mem = w_dataReq & ~r_dmDone;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single accesses plus hand-written
// sequences for back-to-back arbitration, fetch kill, timeout and mid-access reset.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        ifReq;
   logic [63:0] ifAddr;
   logic        ifFlush;
   logic [31:0] ifRdata;
   logic        ifValid;
   logic        stallIf;
   logic        dmRead;
   logic        dmWrite;
   logic [63:0] dmAddr;
   logic [63:0] dmWdata;
   logic [63:0] dmRdata;
   logic        dmDone;
   logic        stallMem;
   logic        timeoutErr;

   int checks;
   int failures;

   mem_port_arbiter_if memBus ();

   mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_if_req      (ifReq),
      .i_if_addr     (ifAddr),
      .i_if_flush    (ifFlush),
      .o_if_rdata    (ifRdata),
      .o_if_valid    (ifValid),
      .o_stall_if    (stallIf),
      .i_dm_read     (dmRead),
      .i_dm_write    (dmWrite),
      .i_dm_addr     (dmAddr),
      .i_dm_wdata    (dmWdata),
      .o_dm_rdata    (dmRdata),
      .o_dm_done     (dmDone),
      .o_stall_mem   (stallMem),
      .o_timeout_err (timeoutErr),
      .mem           (memBus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        isFetch;
      logic        isWrite;
      logic        bothRw;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          latency;
      logic [63:0] expData;
   } vec_t;

   vec_t vecs[7];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   // One isolated access: request in cycle 0, port in cycle 1, ready after 'latency' waits.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      if (v.isFetch) begin
         ifReq  = 1'b1;
         ifAddr = v.addr;
      end else begin
         dmWrite = v.isWrite;
         dmRead  = ~v.isWrite | v.bothRw;
         dmAddr  = v.addr;
         dmWdata = v.wdata;
      end
      #1;
      checkOutput({v.name, ".stallC0"}, {63'b0, v.isFetch ? stallIf : stallMem}, 64'd1);
      @(negedge clk);
      checkOutput({v.name, ".memReq"}, {63'b0, memBus.mem_req}, 64'd1);
      checkOutput({v.name, ".memAddr"}, memBus.mem_addr, v.addr);
      checkOutput({v.name, ".memWe"}, {63'b0, memBus.mem_we}, {63'b0, v.isWrite & ~v.isFetch});
      if (v.isWrite && !v.isFetch) begin
         checkOutput({v.name, ".memWdata"}, memBus.mem_wdata, v.wdata);
      end
      for (int i = 0; i < v.latency; i++) begin
         @(negedge clk);
         checkOutput({v.name, ".addrHeld"}, memBus.mem_addr, v.addr);
      end
      memBus.mem_ready = 1'b1;
      memBus.mem_rdata = v.rdata;
      #1;
      checkOutput({v.name, ".stallReady"}, {63'b0, v.isFetch ? stallIf : stallMem}, 64'd1);
      @(negedge clk);
      memBus.mem_ready = 1'b0;
      memBus.mem_rdata = '0;
      if (v.isFetch) begin
         checkOutput({v.name, ".valid"}, {63'b0, ifValid}, 64'd1);
         checkOutput({v.name, ".ifRdata"}, {32'b0, ifRdata}, v.expData);
         checkOutput({v.name, ".stallDone"}, {63'b0, stallIf}, 64'd0);
      end else begin
         checkOutput({v.name, ".done"}, {63'b0, dmDone}, 64'd1);
         checkOutput({v.name, ".dmRdata"}, dmRdata, v.expData);
         checkOutput({v.name, ".stallDone"}, {63'b0, stallMem}, 64'd0);
      end
      checkOutput({v.name, ".idleReq"}, {63'b0, memBus.mem_req}, 64'd0);
      ifReq   = 1'b0;
      dmRead  = 1'b0;
      dmWrite = 1'b0;
      @(negedge clk);
      checkOutput({v.name, ".pulseEnd"}, {63'b0, v.isFetch ? ifValid : dmDone}, 64'd0);
   endtask

   initial begin
      checks           = 0;
      failures         = 0;
      reset            = 1'b1;
      ifReq            = 1'b0;
      ifAddr           = '0;
      ifFlush          = 1'b0;
      dmRead           = 1'b0;
      dmWrite          = 1'b0;
      dmAddr           = '0;
      dmWdata          = '0;
      memBus.mem_ready = 1'b0;
      memBus.mem_rdata = '0;

      vecs[0] = '{"load0",  1'b0, 1'b0, 1'b0, 64'h100,  64'h0, 64'hDEADBEEF_CAFEF00D, 0, 64'hDEADBEEF_CAFEF00D};
      vecs[1] = '{"store1", 1'b0, 1'b1, 1'b0, 64'h108,  64'h11223344_55667788, 64'hFFFFFFFF_FFFFFFFF, 1, 64'hDEADBEEF_CAFEF00D};
      vecs[2] = '{"fetch4", 1'b1, 1'b0, 1'b0, 64'h4,    64'h0, 64'h00500093_00000013, 0, 64'h00500093};
      vecs[3] = '{"fetch0", 1'b1, 1'b0, 1'b0, 64'h0,    64'h0, 64'h00500093_00000013, 0, 64'h00000013};
      vecs[4] = '{"load3",  1'b0, 1'b0, 1'b0, 64'h2000, 64'h0, 64'h01234567_89ABCDEF, 3, 64'h01234567_89ABCDEF};
      vecs[5] = '{"fetchC", 1'b1, 1'b0, 1'b0, 64'hC,    64'h0, 64'hAAAA5555_12345678, 2, 64'hAAAA5555};
      vecs[6] = '{"bothRw", 1'b0, 1'b1, 1'b1, 64'h3F8,  64'hCAFE0000_0000BEEF, 64'h55555555_55555555, 1, 64'h01234567_89ABCDEF};

      @(negedge clk);
      @(negedge clk);
      checkOutput("rst.memReq",  {63'b0, memBus.mem_req}, 64'd0);
      checkOutput("rst.memWe",   {63'b0, memBus.mem_we}, 64'd0);
      checkOutput("rst.memAddr", memBus.mem_addr, 64'd0);
      checkOutput("rst.memWdata", memBus.mem_wdata, 64'd0);
      checkOutput("rst.dmRdata", dmRdata, 64'd0);
      checkOutput("rst.ifRdata", {32'b0, ifRdata}, 64'd0);
      checkOutput("rst.flags",   {61'b0, dmDone, ifValid, timeoutErr}, 64'd0);
      reset = 1'b0;

      foreach (vecs[i]) applyStimulus(vecs[i]);
      checkOutput("table.noTimeout", {63'b0, timeoutErr}, 64'd0);

      // Store and fetch requested together: store first, fetch back-to-back after it.
      @(negedge clk);
      dmWrite = 1'b1;
      dmAddr  = 64'h200;
      dmWdata = 64'h0BADF00D_00C0FFEE;
      ifReq   = 1'b1;
      ifAddr  = 64'h8;
      @(negedge clk);
      checkOutput("b2b.storeWe",   {63'b0, memBus.mem_we}, 64'd1);
      checkOutput("b2b.storeAddr", memBus.mem_addr, 64'h200);
      @(negedge clk);
      @(negedge clk);
      memBus.mem_ready = 1'b1;
      @(negedge clk);
      memBus.mem_ready = 1'b0;
      checkOutput("b2b.dmDone",    {63'b0, dmDone}, 64'd1);
      checkOutput("b2b.fetchReq",  {63'b0, memBus.mem_req}, 64'd1);
      checkOutput("b2b.fetchWe",   {63'b0, memBus.mem_we}, 64'd0);
      checkOutput("b2b.fetchAddr", memBus.mem_addr, 64'h8);
      dmWrite = 1'b0;
      @(negedge clk);
      checkOutput("b2b.noRegrant", memBus.mem_addr, 64'h8);
      @(negedge clk);
      memBus.mem_ready = 1'b1;
      memBus.mem_rdata = 64'h76543210_FEDCBA98;
      @(negedge clk);
      memBus.mem_ready = 1'b0;
      checkOutput("b2b.ifValid", {63'b0, ifValid}, 64'd1);
      checkOutput("b2b.ifRdata", {32'b0, ifRdata}, 64'hFEDCBA98);
      ifReq = 1'b0;

      // Redirect during an outstanding fetch: old response discarded, new address fetched.
      @(negedge clk);
      ifReq  = 1'b1;
      ifAddr = 64'h10;
      @(negedge clk);
      checkOutput("kill.firstAddr", memBus.mem_addr, 64'h10);
      @(negedge clk);
      ifFlush = 1'b1;
      ifAddr  = 64'h40;
      @(negedge clk);
      ifFlush = 1'b0;
      @(negedge clk);
      memBus.mem_ready = 1'b1;
      memBus.mem_rdata = 64'h99999999_99999999;
      @(negedge clk);
      memBus.mem_ready = 1'b1;
      memBus.mem_rdata = 64'h00000000_00A00113;
      checkOutput("kill.noValid",  {63'b0, ifValid}, 64'd0);
      checkOutput("kill.newReq",   {63'b0, memBus.mem_req}, 64'd1);
      checkOutput("kill.newAddr",  memBus.mem_addr, 64'h40);
      @(negedge clk);
      memBus.mem_ready = 1'b0;
      checkOutput("kill.newValid", {63'b0, ifValid}, 64'd1);
      checkOutput("kill.newRdata", {32'b0, ifRdata}, 64'h00A00113);
      ifReq = 1'b0;

      // Ready withheld: error after four wait cycles, access still completes later.
      @(negedge clk);
      dmRead = 1'b1;
      dmAddr = 64'h300;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
      end
      checkOutput("to.beforeLimit", {63'b0, timeoutErr}, 64'd0);
      @(negedge clk);
      checkOutput("to.errSet", {63'b0, timeoutErr}, 64'd1);
      checkOutput("to.reqHeld", {63'b0, memBus.mem_req}, 64'd1);
      @(negedge clk);
      @(negedge clk);
      memBus.mem_ready = 1'b1;
      memBus.mem_rdata = 64'h13579BDF_2468ACE0;
      @(negedge clk);
      memBus.mem_ready = 1'b0;
      checkOutput("to.done",   {63'b0, dmDone}, 64'd1);
      checkOutput("to.rdata",  dmRdata, 64'h13579BDF_2468ACE0);
      dmRead = 1'b0;
      @(negedge clk);
      checkOutput("to.sticky", {63'b0, timeoutErr}, 64'd1);

      // Reset mid-access: request drops before any clock edge.
      dmRead = 1'b1;
      dmAddr = 64'h400;
      @(negedge clk);
      checkOutput("rstMid.reqBefore", {63'b0, memBus.mem_req}, 64'd1);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("rstMid.memReq", {63'b0, memBus.mem_req}, 64'd0);
      checkOutput("rstMid.flags",  {61'b0, dmDone, ifValid, timeoutErr}, 64'd0);
      dmRead = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("rstMid.idle", {63'b0, memBus.mem_req}, 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
